// File: rtl/imm_narrower.sv
// imm_narrower: two-stage pipelined narrowing of a 32-bit signed value to a 17-bit immediate.
// Flags values outside [-65536, 65535]; optionally clamps them instead of truncating.
// Keeps a saturating count of overflowed results delivered downstream.
//
// Ports:
//   clock      single clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   upstream presents in_data/in_sat
//   in_ready   unit can accept this cycle (combinational from out_ready)
//   in_data    32-bit signed value to narrow
//   in_sat     1 = clamp on overflow, 0 = truncate
//   out_valid  out_imm/out_ovf valid
//   out_ready  downstream accepts this cycle
//   out_imm    17-bit narrowed immediate
//   out_ovf    input was not representable in 17 bits
//   clr_count  synchronous clear of ovf_count (wins over increment)
//   ovf_count  saturating count of overflowed results delivered
module imm_narrower (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] out_imm,
  output logic        out_ovf,
  input  logic        clr_count,
  output logic [15:0] ovf_count
);

  localparam logic [16:0] ImmMax = 17'h0FFFF;
  localparam logic [16:0] ImmMin = 17'h10000;

  // Stage 1: only the bits needed to build the result are kept.
  logic        s1_valid_q, s1_valid_d;
  logic [16:0] s1_low_q, s1_low_d;
  logic        s1_neg_q, s1_neg_d;
  logic        s1_sat_q, s1_sat_d;
  logic        s1_fits_q, s1_fits_d;

  // Stage 2: final result register.
  logic        s2_valid_q, s2_valid_d;
  logic [16:0] s2_imm_q, s2_imm_d;
  logic        s2_ovf_q, s2_ovf_d;

  logic [15:0] cnt_q, cnt_d;

  logic s2_adv, s1_adv, accept, out_hs, in_fits;

  // Fits iff bits 31:16 all replicate bit 16.
  assign in_fits = (in_data[31:16] == {16{in_data[16]}});

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = s1_valid_q & s2_adv;
  assign in_ready = ~s1_valid_q | s2_adv;
  assign accept   = in_valid & in_ready;
  assign out_hs   = s2_valid_q & out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_low_d   = s1_low_q;
    s1_neg_d   = s1_neg_q;
    s1_sat_d   = s1_sat_q;
    s1_fits_d  = s1_fits_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_low_d   = in_data[16:0];
      s1_neg_d   = in_data[31];
      s1_sat_d   = in_sat;
      s1_fits_d  = in_fits;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_imm_d   = s2_imm_q;
    s2_ovf_d   = s2_ovf_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_adv) begin
      if (s1_fits_q) begin
        s2_imm_d = s1_low_q;
        s2_ovf_d = 1'b0;
      end else if (s1_sat_q) begin
        s2_imm_d = s1_neg_q ? ImmMin : ImmMax;
        s2_ovf_d = 1'b1;
      end else begin
        s2_imm_d = s1_low_q;
        s2_ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (out_hs && s2_ovf_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_low_q   <= '0;
      s1_neg_q   <= 1'b0;
      s1_sat_q   <= 1'b0;
      s1_fits_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_imm_q   <= '0;
      s2_ovf_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_low_q   <= s1_low_d;
      s1_neg_q   <= s1_neg_d;
      s1_sat_q   <= s1_sat_d;
      s1_fits_q  <= s1_fits_d;
      s2_valid_q <= s2_valid_d;
      s2_imm_q   <= s2_imm_d;
      s2_ovf_q   <= s2_ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_imm   = s2_imm_q;
  assign out_ovf   = s2_ovf_q;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_imm_narrower.sv
// Directed and scoreboarded bench for imm_narrower.
module tb_imm_narrower;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sat;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_imm;
  logic        out_ovf;
  logic        clr_count;
  logic [15:0] ovf_count;

  int passed;
  int total;

  imm_narrower dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sat    (in_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_ovf   (out_ovf),
    .clr_count (clr_count),
    .ovf_count (ovf_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: {ovf, imm} from a numeric range test.
  function automatic logic [17:0] model(input logic [31:0] d, input logic s);
    int v;
    v = $signed(d);
    if (v >= -65536 && v <= 65535) return {1'b0, d[16:0]};
    if (!s) return {1'b1, d[16:0]};
    if (v < 0) return {1'b1, 17'h10000};
    return {1'b1, 17'h0FFFF};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sat    = 1'b0;
    clr_count = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    do_reset();
    #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passed++;
    total++;
    if (ovf_count !== 16'h0) $display("FAIL reset_count: got %h want 0000", ovf_count);
    else passed++;
    total++;
    if (out_imm !== 17'h0 || out_ovf !== 1'b0)
      $display("FAIL reset_out_data: got imm %h ovf %b want 00000/0", out_imm, out_ovf);
    else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] vin [4];
    logic [16:0] vimm[4];
    logic        vovf[4];
    vin  = '{32'h0000_1234, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFE_FFFF};
    vimm = '{17'h01234, 17'h10000, 17'h0FFFF, 17'h0FFFF};
    vovf = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      #1;
      if (i == 1) begin
        total++;
        if (out_valid !== 1'b0) $display("FAIL stream_latency: got out_valid %b want 0", out_valid);
        else passed++;
      end
      if (i >= 2) begin
        total++;
        if (out_valid !== 1'b1 || out_imm !== vimm[i-2] || out_ovf !== vovf[i-2])
          $display("FAIL stream_item%0d: got v%b imm %h ovf %b want v1 imm %h ovf %b",
                   i - 2, out_valid, out_imm, out_ovf, vimm[i-2], vovf[i-2]);
        else passed++;
      end
      in_valid = (i < 4);
      in_sat   = 1'b0;
      in_data  = (i < 4) ? vin[i] : 32'h0;
    end
    @(negedge clock);
    #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL stream_drain: got out_valid %b want 0", out_valid);
    else passed++;
    total++;
    if (ovf_count !== 16'd1) $display("FAIL stream_count: got %0d want 1", ovf_count);
    else passed++;
  endtask

  task automatic test_sat();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      if (i == 2) begin
        total++;
        if (out_valid !== 1'b1 || out_imm !== 17'h0FFFF || out_ovf !== 1'b1)
          $display("FAIL sat_pos: got v%b imm %h ovf %b want v1 imm 0ffff ovf 1",
                   out_valid, out_imm, out_ovf);
        else passed++;
      end
      if (i == 3) begin
        total++;
        if (out_valid !== 1'b1 || out_imm !== 17'h10000 || out_ovf !== 1'b1)
          $display("FAIL sat_neg: got v%b imm %h ovf %b want v1 imm 10000 ovf 1",
                   out_valid, out_imm, out_ovf);
        else passed++;
      end
      in_valid = (i < 2);
      in_sat   = 1'b1;
      in_data  = (i == 0) ? 32'h0001_0000 : 32'h8000_0000;
    end
    @(negedge clock);
    #1;
    total++;
    if (ovf_count !== 16'd2) $display("FAIL sat_count: got %0d want 2", ovf_count);
    else passed++;
    in_sat = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] bp[3];
    int accepts;
    bp = '{32'h0000_0111, 32'hFFFF_FF00, 32'h0000_0222};
    accepts = 0;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_sat   = 1'b0;
      in_data  = bp[(accepts > 2) ? 2 : accepts];
      #1;
      if (c >= 2) begin
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 17'h00111)
          $display("FAIL bp_hold_c%0d: got rdy %b v %b imm %h want rdy 0 v 1 imm 00111",
                   c, in_ready, out_valid, out_imm);
        else passed++;
      end
      if (in_ready) accepts++;
    end
    total++;
    if (accepts != 2) $display("FAIL bp_accepts: got %0d want 2", accepts);
    else passed++;
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_imm !== 17'h00111)
      $display("FAIL bp_first: got v%b imm %h want v1 imm 00111", out_valid, out_imm);
    else passed++;
    @(negedge clock);
    #1;
    total++;
    if (out_valid !== 1'b1 || out_imm !== 17'h1FF00)
      $display("FAIL bp_second: got v%b imm %h want v1 imm 1ff00", out_valid, out_imm);
    else passed++;
    @(negedge clock);
    #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty: got out_valid %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_random();
    logic [17:0] exp_q[$];
    logic [17:0] exp;
    logic [31:0] bnd[4];
    int sent;
    int ovf_exp;
    int cyc;
    bnd = '{32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFE_FFFF};
    sent = 0;
    ovf_exp = 0;
    cyc = 0;
    do_reset();
    while ((sent < 200 || exp_q.size() != 0) && cyc < 3000) begin
      @(negedge clock);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_extra: got imm %h ovf %b with nothing expected", out_imm, out_ovf);
        end else begin
          exp = exp_q.pop_front();
          if ({out_ovf, out_imm} !== exp)
            $display("FAIL rand_item: got ovf %b imm %h want ovf %b imm %h",
                     out_ovf, out_imm, exp[17], exp[16:0]);
          else passed++;
          if (exp[17]) ovf_exp++;
        end
      end
      in_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
      in_sat   = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 3))
        0:       in_data = $urandom();
        1:       in_data = 32'($urandom_range(0, 131071)) - 32'd65536;
        2:       in_data = bnd[$urandom_range(0, 3)];
        default: in_data = 32'($urandom_range(0, 262143)) - 32'd131072;
      endcase
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, in_sat));
        sent++;
      end
      cyc++;
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    total++;
    if (sent != 200 || exp_q.size() != 0)
      $display("FAIL rand_drain: got sent %0d left %0d want 200/0", sent, exp_q.size());
    else passed++;
    total++;
    if (ovf_count !== 16'(ovf_exp))
      $display("FAIL rand_count: got %0d want %0d", ovf_count, ovf_exp);
    else passed++;
  endtask

  task automatic test_counter_sat();
    do_reset();
    out_ready = 1'b1;
    @(negedge clock);
    force dut.cnt_q = 16'hFFFF;
    @(negedge clock);
    release dut.cnt_q;
    #1;
    total++;
    if (ovf_count !== 16'hFFFF) $display("FAIL cnt_forced: got %h want ffff", ovf_count);
    else passed++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_sat   = 1'b0;
      in_data  = 32'h0002_0000;
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      #1;
      total++;
      if (out_valid !== 1'b1 || out_ovf !== 1'b1 || out_imm !== 17'h00000)
        $display("FAIL cnt_item%0d: got v%b ovf %b imm %h want v1 ovf 1 imm 00000",
                 k, out_valid, out_ovf, out_imm);
      else passed++;
      clr_count = (k == 1);
      @(negedge clock);
      clr_count = 1'b0;
      #1;
      total++;
      if (ovf_count !== ((k == 0) ? 16'hFFFF : 16'h0000))
        $display("FAIL cnt_after%0d: got %h want %h",
                 k, ovf_count, (k == 0) ? 16'hFFFF : 16'h0000);
      else passed++;
    end
  endtask

  task automatic test_reset_flush();
    do_reset();
    out_ready = 1'b0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 32'h0000_0AAA;
    @(negedge clock);
    in_data  = 32'h7000_0000;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL flush_full: got rdy %b v %b want rdy 0 v 1", in_ready, out_valid);
    else passed++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_count !== 16'h0)
      $display("FAIL flush_state: got v %b rdy %b cnt %h want v 0 rdy 1 cnt 0000",
               out_valid, in_ready, ovf_count);
    else passed++;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      #1;
      total++;
      if (out_valid !== 1'b0)
        $display("FAIL flush_ghost_c%0d: got out_valid %b imm %h want 0", c, out_valid, out_imm);
      else passed++;
    end
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sat    = 1'b0;
    out_ready = 1'b0;
    clr_count = 1'b0;
    test_reset();
    test_stream();
    test_sat();
    test_backpressure();
    test_random();
    test_counter_sat();
    test_reset_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
